// File: rtl/pipe_rx_pkg.sv
// ============================================================================
// Module : pipe_rx_pkg
// Brief  : Shared defaults, derived widths and word type for the pipe_rx FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_rx_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int DROP_CNT_WIDTH_DEF = 8;
    localparam int DEPTH_DEF          = 4;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = $clog2(DEPTH_DEF) + 1;
    localparam int LVL_W = $clog2(DEPTH_DEF) + 1;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : pipe_rx_pkg

`default_nettype wire

// File: rtl/pipe_rx_mem.sv
// ============================================================================
// Module : pipe_rx_mem
// Brief  : DEPTH x DATA_WIDTH register array, synchronous write, async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_rx_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally left unreset; out_vld gates its visibility.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : pipe_rx_mem

`default_nettype wire

// File: rtl/pipe_rx_fifo.sv
// ============================================================================
// Module : pipe_rx_fifo
// Brief  : Drop-on-full capture FIFO behind a stall-free pipeline, FWFT output.
//          Optional saturating drop counter under macro PIPE_RX_DROP_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_rx_fifo
    import pipe_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_vld,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_vld,
    input  logic                        out_rd,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
`ifdef PIPE_RX_DROP_CNT_EN
    output logic [DROP_CNT_WIDTH-1:0]   drop_cnt,
`endif
    input  logic                        clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic                  ovf_q, ovf_d;
    logic                  empty_w, full_w;
    logic                  push_w, pop_w, drop_w;
    logic [DATA_WIDTH-1:0] rdata_w;

    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    assign pop_w   = !empty_w && out_rd;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push_w  = in_vld && (!full_w || pop_w);
    assign drop_w  = in_vld && !push_w;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (push_w) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_w) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (drop_w) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    pipe_rx_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_w),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (rdata_w)
    );

    // Modulo-2*DEPTH difference of the pointers is exactly the occupancy.
    assign level    = wptr_q - rptr_q;
    assign out_vld  = !empty_w;
    assign out_data = empty_w ? '0 : rdata_w;
    assign overflow = ovf_q;

`ifdef PIPE_RX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drop_w) begin
            if (clr_ovf) begin
                cnt_d = DROP_CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + DROP_CNT_WIDTH'(1);
            end
        end else if (clr_ovf) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;
`endif

endmodule : pipe_rx_fifo

`default_nettype wire

// File: tb/tb_pipe_rx_fifo.sv
// ============================================================================
// Module : tb_pipe_rx_fifo
// Brief  : Directed self-checking bench for pipe_rx_fifo (DEPTH=4, 8-bit).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_vld;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_rd;
    logic [2:0] level;
    logic       overflow;
    logic       clr_ovf;
`ifdef PIPE_RX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_rx_fifo #(
        .DATA_WIDTH     (8),
        .DEPTH          (4),
        .DROP_CNT_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rd   (out_rd),
        .level    (level),
        .overflow (overflow),
`ifdef PIPE_RX_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            in_vld  = 1'b1;
            in_data = 8'(i);
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic drain(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_q [4];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        out_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_vld", 32'(out_vld), 32'd1);
            chk("drain_data", 32'(out_data), 32'(exp_q[k]));
            tick();
        end
        out_rd = 1'b0;
        chk("drain_empty_vld", 32'(out_vld), 32'd0);
        chk("drain_empty_lvl", 32'(level), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_data = 8'h00;
        in_vld  = 1'b0;
        out_rd  = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
`ifdef PIPE_RX_DROP_CNT_EN
        chk("rst_cnt", 32'(drop_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_vld", 32'(out_vld), 32'd0);
            chk("idle_lvl", 32'(level), 32'd0);
            chk("idle_ovf", 32'(overflow), 32'd0);
        end

        // Single-word latency
        in_vld = 1'b1; in_data = 8'h05;
        tick();
        in_vld = 1'b0;
        chk("lat_vld", 32'(out_vld), 32'd1);
        chk("lat_data", 32'(out_data), 32'h05);
        chk("lat_lvl", 32'(level), 32'd1);
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        chk("lat_pop_vld", 32'(out_vld), 32'd0);
        chk("lat_pop_lvl", 32'(level), 32'd0);

        // Empty with in_vld and out_rd: store only
        in_vld = 1'b1; in_data = 8'h33; out_rd = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("emp_rw_lvl", 32'(level), 32'd1);
        chk("emp_rw_data", 32'(out_data), 32'h33);
        tick();
        out_rd = 1'b0;
        chk("emp_rw_pop", 32'(level), 32'd0);

        // Fill and drop
        for (int i = 1; i <= 6; i++) begin
            in_vld  = 1'b1;
            in_data = 8'(i);
            tick();
            chk("fill_lvl", 32'(level), (i < 4) ? 32'(i) : 32'd4);
            chk("fill_ovf", 32'(overflow), (i >= 5) ? 32'd1 : 32'd0);
        end
        in_vld = 1'b0;
`ifdef PIPE_RX_DROP_CNT_EN
        chk("fill_cnt", 32'(drop_cnt), 32'd2);
`endif
        drain(8'h01, 8'h02, 8'h03, 8'h04);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        fill4();
        chk("full_lvl", 32'(level), 32'd4);
        in_vld = 1'b1; in_data = 8'h10; out_rd = 1'b1;
        tick();
        in_vld = 1'b0; out_rd = 1'b0;
        chk("fsim_lvl", 32'(level), 32'd4);
        chk("fsim_ovf", 32'(overflow), 32'd0);
        drain(8'h02, 8'h03, 8'h04, 8'h10);

        // clr_ovf racing a drop
        fill4();
        in_vld = 1'b1; in_data = 8'hEE;
        tick(); tick(); tick();
        chk("drop3_ovf", 32'(overflow), 32'd1);
`ifdef PIPE_RX_DROP_CNT_EN
        chk("drop3_cnt", 32'(drop_cnt), 32'd3);
`endif
        clr_ovf = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
`ifdef PIPE_RX_DROP_CNT_EN
        chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
`endif
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef PIPE_RX_DROP_CNT_EN
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
`endif
        chk("clr_keep_lvl", 32'(level), 32'd4);
        chk("clr_head", 32'(out_data), 32'h01);

        // Asynchronous reset mid-stream
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        chk("pre_rst_lvl", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_vld), 32'd0);
        chk("arst_lvl", 32'(level), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        in_vld = 1'b1; in_data = 8'hAA;
        tick();
        in_vld = 1'b0;
        chk("post_rst_data", 32'(out_data), 32'hAA);
        chk("post_rst_lvl", 32'(level), 32'd1);
        chk("post_rst_vld", 32'(out_vld), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipe_rx_fifo

`default_nettype wire
